led_pwm_module: RTL and testbench



---
 rtl/led_pwm_module.sv | 134 +++++++++++++
 tb/tb_led_pwm_module.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/led_pwm_module.sv
// rtl/led_pwm_module.sv - register-bus LED controller with per-channel on/off, PWM dimming and blink
module led_pwm_module #(
    parameter int          NUM_LEDS = 3,
    parameter logic [14:0] BASE     = 15'h0100,
    parameter int          PRESCALE = 196
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [30:0]         addr_bus,
    input  logic [31:0]         data_bus_wr,
    output logic [31:0]         data_bus_rd,
    input  logic                wr_strobe,
    input  logic                rd_strobe,
    output logic [NUM_LEDS-1:0] leds
);

    localparam logic [1:0]  MODE_OFF   = 2'd0;
    localparam logic [1:0]  MODE_ON    = 2'd1;
    localparam logic [1:0]  MODE_PWM   = 2'd2;
    localparam logic [1:0]  MODE_BLINK = 2'd3;
    localparam logic [15:0] PRESC_MAX  = 16'(PRESCALE - 1);

    logic [NUM_LEDS-1:0][1:0]  mode_q, mode_d;
    logic [NUM_LEDS-1:0][7:0]  duty_q, duty_d;
    logic [NUM_LEDS-1:0][15:0] hp_q, hp_d;
    logic [NUM_LEDS-1:0][15:0] fc_q, fc_d;
    logic [NUM_LEDS-1:0]       phase_q, phase_d;
    logic [NUM_LEDS-1:0]       led_q, led_d;
    logic [15:0]               presc_q, presc_d;
    logic [7:0]                pwm_q, pwm_d;
    logic [31:0]               rd_data_q, rd_data_d;

    logic                      sel, wr_en, rd_en, tick, frame_end;
    logic [7:0]                idx;
    logic [NUM_LEDS-1:0]       cfg_wr;
    logic [NUM_LEDS-1:0][15:0] hp_eff;
    logic [31:0]               rd_val;
    logic                      unused_bits;

    assign unused_bits = ^{addr_bus[15:8], data_bus_wr[7:2]};

    always_comb begin
        sel       = (addr_bus[30:16] == BASE);
        idx       = addr_bus[7:0];
        wr_en     = sel && wr_strobe;
        rd_en     = sel && rd_strobe;

        tick      = (presc_q == PRESC_MAX);
        presc_d   = tick ? 16'd0 : presc_q + 16'd1;
        pwm_d     = tick ? pwm_q + 8'd1 : pwm_q;
        frame_end = tick && (pwm_q == 8'hFF);

        mode_d  = mode_q;
        duty_d  = duty_q;
        hp_d    = hp_q;
        fc_d    = fc_q;
        phase_d = phase_q;
        led_d   = '0;
        cfg_wr  = '0;
        hp_eff  = '0;
        rd_val  = 32'd0;

        for (int i = 0; i < NUM_LEDS; i++) begin
            case (mode_q[i])
                MODE_OFF:   led_d[i] = 1'b0;
                MODE_ON:    led_d[i] = 1'b1;
                MODE_PWM:   led_d[i] = (pwm_q < duty_q[i]);
                default:    led_d[i] = phase_q[i] && (pwm_q < duty_q[i]);
            endcase

            if (wr_en && idx == 8'd0) begin
                mode_d[i] = data_bus_wr[i] ? MODE_ON : MODE_OFF;
                cfg_wr[i] = 1'b1;
            end
            if (wr_en && idx == 8'(i + 1)) begin
                mode_d[i] = data_bus_wr[1:0];
                duty_d[i] = data_bus_wr[15:8];
                hp_d[i]   = data_bus_wr[31:16];
                cfg_wr[i] = 1'b1;
            end

            // A config write restarts the blink in its lit phase, even on a frame boundary
            hp_eff[i] = (hp_q[i] == 16'd0) ? 16'd1 : hp_q[i];
            if (cfg_wr[i]) begin
                fc_d[i]    = 16'd0;
                phase_d[i] = 1'b1;
            end else if (mode_q[i] == MODE_BLINK && frame_end) begin
                if ({1'b0, fc_q[i]} + 17'd1 >= {1'b0, hp_eff[i]}) begin
                    fc_d[i]    = 16'd0;
                    phase_d[i] = ~phase_q[i];
                end else begin
                    fc_d[i] = fc_q[i] + 16'd1;
                end
            end

            if (idx == 8'(i + 1)) begin
                rd_val = {hp_q[i], duty_q[i], 6'd0, mode_q[i]};
            end
        end

        if (idx == 8'd0) begin
            rd_val[NUM_LEDS-1:0] = led_q;
        end
        rd_data_d = rd_en ? rd_val : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= '0;
            duty_q    <= '0;
            hp_q      <= '0;
            fc_q      <= '0;
            phase_q   <= '1;
            led_q     <= '0;
            presc_q   <= 16'd0;
            pwm_q     <= 8'd0;
            rd_data_q <= 32'd0;
        end else begin
            mode_q    <= mode_d;
            duty_q    <= duty_d;
            hp_q      <= hp_d;
            fc_q      <= fc_d;
            phase_q   <= phase_d;
            led_q     <= led_d;
            presc_q   <= presc_d;
            pwm_q     <= pwm_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign leds        = ~led_q;
    assign data_bus_rd = rd_data_q;

endmodule

// File: tb/tb_led_pwm_module.sv
// tb/tb_led_pwm_module.sv - directed self-checking bench for led_pwm_module
module tb_led_pwm_module;

    localparam logic [14:0] BASE  = 15'h0100;
    localparam logic [14:0] OTHER = 15'h0200;

    logic        clk = 1'b0;
    logic        reset;
    logic [30:0] addr_bus;
    logic [31:0] data_bus_wr;
    logic [31:0] data_bus_rd;
    logic        wr_strobe;
    logic        rd_strobe;
    logic [2:0]  leds;

    int n_checks = 0;
    int n_err    = 0;
    logic [7:0]  pc;
    logic [31:0] rv;
    int          cnt;

    led_pwm_module #(.NUM_LEDS(3), .BASE(BASE), .PRESCALE(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .addr_bus    (addr_bus),
        .data_bus_wr (data_bus_wr),
        .data_bus_rd (data_bus_rd),
        .wr_strobe   (wr_strobe),
        .rd_strobe   (rd_strobe),
        .leds        (leds)
    );

    always #5 clk = ~clk;

    // Frame position with PRESCALE=1: one step per cycle since reset
    always @(posedge clk) begin
        if (reset) pc <= 8'd0;
        else       pc <= pc + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [14:0] base, input logic [7:0] idx, input logic [31:0] data);
        addr_bus    = {base, 8'h00, idx};
        data_bus_wr = data;
        wr_strobe   = 1'b1;
        @(negedge clk);
        wr_strobe   = 1'b0;
    endtask

    task automatic bus_read(input logic [14:0] base, input logic [7:0] idx, output logic [31:0] data);
        addr_bus  = {base, 8'h00, idx};
        rd_strobe = 1'b1;
        @(negedge clk);
        data      = data_bus_rd;
        rd_strobe = 1'b0;
    endtask

    task automatic count_lit(input int ch, input int n, output int c);
        c = 0;
        for (int k = 0; k < n; k++) begin
            if (leds[ch] == 1'b0) c++;
            @(negedge clk);
        end
    endtask

    task automatic wait_pc(input logic [7:0] v);
        for (int k = 0; k < 300 && pc != v; k++) @(negedge clk);
        chk("wait_pc", {24'd0, pc}, {24'd0, v});
    endtask

    initial begin
        reset = 1'b1; addr_bus = '0; data_bus_wr = '0; wr_strobe = 1'b0; rd_strobe = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 10; k++) begin
            chk("idle_leds", {29'd0, leds}, 32'h7);
            chk("idle_rd", data_bus_rd, 32'h0);
            @(negedge clk);
        end

        bus_write(BASE, 8'd0, 32'h5);
        chk("direct_lat1", {29'd0, leds}, 32'h7);
        @(negedge clk);
        chk("direct_lat2", {29'd0, leds}, 32'h2);
        bus_read(BASE, 8'd0, rv);
        chk("direct_rd", rv, 32'h5);
        @(negedge clk);
        chk("direct_rd_clr", data_bus_rd, 32'h0);

        bus_write(BASE, 8'd5, 32'h3);
        bus_write(OTHER, 8'd1, 32'h1);
        repeat (2) @(negedge clk);
        chk("bad_wr_leds", {29'd0, leds}, 32'h2);
        bus_read(BASE, 8'd5, rv);
        chk("rd_idx5", rv, 32'h0);
        bus_read(BASE, 8'd4, rv);
        chk("rd_idx4", rv, 32'h0);
        bus_read(OTHER, 8'd1, rv);
        chk("rd_other", rv, 32'h0);

        bus_write(BASE, 8'd0, 32'h0);
        bus_write(BASE, 8'd1, 32'h0000_4002);
        @(negedge clk);
        count_lit(0, 256, cnt);
        chk("pwm_40", cnt, 64);
        bus_write(BASE, 8'd1, 32'h0000_0002);
        @(negedge clk);
        count_lit(0, 256, cnt);
        chk("pwm_00", cnt, 0);
        bus_write(BASE, 8'd1, 32'h0000_FF02);
        @(negedge clk);
        count_lit(0, 256, cnt);
        chk("pwm_ff", cnt, 255);
        bus_read(BASE, 8'd1, rv);
        chk("ctrl0_rd", rv, 32'h0000_FF02);
        bus_write(BASE, 8'd1, 32'h0);

        wait_pc(8'd255);
        bus_write(BASE, 8'd2, 32'h0002_FF03);
        @(negedge clk);
        count_lit(1, 512, cnt);
        chk("blink_on", cnt, 510);
        count_lit(1, 256, cnt);
        chk("blink_dark", cnt, 0);
        wait_pc(8'd127);
        bus_write(BASE, 8'd2, 32'h0002_FF03);
        @(negedge clk);
        count_lit(1, 384, cnt);
        chk("blink_restart_on", cnt, 382);
        count_lit(1, 128, cnt);
        chk("blink_restart_dark", cnt, 0);

        bus_write(BASE, 8'd3, 32'h0001_8003);
        repeat (100) @(negedge clk);
        reset       = 1'b1;
        addr_bus    = {BASE, 16'h0001};
        data_bus_wr = 32'h0000_0001;
        wr_strobe   = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        wr_strobe = 1'b0;
        chk("reset_leds", {29'd0, leds}, 32'h7);
        for (int i = 1; i <= 3; i++) begin
            bus_read(BASE, 8'(i), rv);
            chk($sformatf("reset_ctrl%0d", i - 1), rv, 32'h0);
        end
        chk("reset_leds_hold", {29'd0, leds}, 32'h7);

        bus_write(BASE, 8'd3, 32'h1234_56FE);
        bus_read(BASE, 8'd3, rv);
        chk("ctrl2_mask", rv, 32'h1234_5602);
        addr_bus    = {BASE, 16'h0003};
        data_bus_wr = 32'hABCD_EF03;
        wr_strobe   = 1'b1;
        rd_strobe   = 1'b1;
        @(negedge clk);
        wr_strobe = 1'b0;
        rd_strobe = 1'b0;
        chk("rdwr_old", data_bus_rd, 32'h1234_5602);
        bus_read(BASE, 8'd3, rv);
        chk("rdwr_new", rv, 32'hABCD_EF03);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
